// File: rtl/fc_layer_engine_if.sv
// Memory-side bus of the fully-connected layer engine: start handshake, operand read
// ports (data/weight/bias) and the result write port toward the temp RAM.
interface fc_layer_engine_if #(
    parameter int unsigned N_IN   = 48,
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned DAW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned WAW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
    localparam int unsigned OAW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                     start;
    logic signed [DATA_W-1:0] curdata;
    logic signed [DATA_W-1:0] curweight;
    logic signed [DATA_W-1:0] curbias;
    logic [DAW-1:0]           data_addr;
    logic [WAW-1:0]           weight_addr;
    logic [OAW-1:0]           bias_addr;
    logic [OAW-1:0]           temp_addr;
    logic signed [DATA_W-1:0] temp_data;
    logic                     temp_wren;
    logic                     busy;
    logic                     ready;

    modport master (
        input  start, curdata, curweight, curbias,
        output data_addr, weight_addr, bias_addr, temp_addr, temp_data, temp_wren, busy, ready
    );

    modport slave (
        output start, curdata, curweight, curbias,
        input  data_addr, weight_addr, bias_addr, temp_addr, temp_data, temp_wren, busy, ready
    );
endinterface

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: per-neuron fixed-point dot product plus bias, saturated and
// written to temp RAM. Optional ReLU output stage compiled in with `define FC_RELU_EN.
module fc_layer_engine #(
    parameter int unsigned N_IN      = 48,
    parameter int unsigned N_OUT     = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAC_BITS = 16,
    parameter int unsigned MEM_LAT   = 1
) (
    input logic            Clk,
    input logic            Reset,
    fc_layer_engine_if.master bus
);
    localparam int unsigned DAW   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned WAW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
    localparam int unsigned OAW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N_IN) + 1;
    localparam int unsigned PW    = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StIssue, StDrain, StWrite, StDone} state_e;

    state_e                   state_q, state_d;
    logic [DAW-1:0]           k_q, k_d;
    logic [OAW-1:0]           neuron_q, neuron_d;
    logic [WAW-1:0]           waddr_q, waddr_d;
    logic [1:0]               drain_q, drain_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] bias_q, bias_d;
    logic signed [DATA_W-1:0] tdata_q, tdata_d;
    logic [MEM_LAT-1:0]       tag_q, tag_d;
    logic [MEM_LAT-1:0]       first_q, first_d;

    logic                     issue, first_in;
    logic                     last_k, last_n;
    logic signed [PW-1:0]     data_ext, weight_ext, prod, prod_sh;
    logic signed [ACC_W-1:0]  prod_acc, sum;
    logic signed [DATA_W-1:0] res;

    assign issue    = (state_q == StIssue);
    assign first_in = issue && (k_q == '0);
    assign last_k   = (k_q == DAW'(N_IN - 1));
    assign last_n   = (neuron_q == OAW'(N_OUT - 1));

    // Valid and first-of-neuron tags ride alongside each issued address for MEM_LAT cycles.
    if (MEM_LAT == 1) begin : g_tag1
        assign tag_d   = issue;
        assign first_d = first_in;
    end else begin : g_tagn
        assign tag_d   = {tag_q[MEM_LAT-2:0], issue};
        assign first_d = {first_q[MEM_LAT-2:0], first_in};
    end

    assign data_ext   = {{DATA_W{bus.curdata[DATA_W-1]}}, bus.curdata};
    assign weight_ext = {{DATA_W{bus.curweight[DATA_W-1]}}, bus.curweight};
    assign prod       = data_ext * weight_ext;
    assign prod_sh    = prod >>> FRAC_BITS;
    assign prod_acc   = {{(ACC_W-PW){prod_sh[PW-1]}}, prod_sh};
    assign sum        = acc_q + {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};

    always_comb begin
        res = sum[DATA_W-1:0];
`ifdef FC_RELU_EN
        if (sum < 0) begin
            res = '0;
        end else if (sum > SatMax) begin
            res = SatMax[DATA_W-1:0];
        end
`else
        if (sum > SatMax) begin
            res = SatMax[DATA_W-1:0];
        end else if (sum < SatMin) begin
            res = SatMin[DATA_W-1:0];
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        neuron_d = neuron_q;
        waddr_d  = waddr_q;
        drain_d  = drain_q;
        acc_d    = acc_q;
        bias_d   = bias_q;
        tdata_d  = tdata_q;

        if (tag_q[MEM_LAT-1]) begin
            acc_d = acc_q + prod_acc;
        end
        if (first_q[MEM_LAT-1]) begin
            bias_d = bus.curbias;
        end

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StIssue;
                    k_d      = '0;
                    neuron_d = '0;
                    waddr_d  = '0;
                    acc_d    = '0;
                end
            end
            StIssue: begin
                // Addresses freeze on the last index so they hold through DRAIN.
                if (last_k) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    k_d     = k_q + DAW'(1);
                    waddr_d = waddr_q + WAW'(1);
                end
            end
            StDrain: begin
                if (drain_q == 2'(MEM_LAT - 1)) begin
                    state_d = StWrite;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            StWrite: begin
                tdata_d = res;
                acc_d   = '0;
                if (last_n) begin
                    state_d = StDone;
                end else begin
                    state_d  = StIssue;
                    neuron_d = neuron_q + OAW'(1);
                    k_d      = '0;
                    waddr_d  = waddr_q + WAW'(1);
                end
            end
            StDone: begin
                state_d  = StIdle;
                neuron_d = '0;
                k_d      = '0;
                waddr_d  = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            neuron_q <= '0;
            waddr_q  <= '0;
            drain_q  <= '0;
            acc_q    <= '0;
            bias_q   <= '0;
            tdata_q  <= '0;
            tag_q    <= '0;
            first_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            neuron_q <= neuron_d;
            waddr_q  <= waddr_d;
            drain_q  <= drain_d;
            acc_q    <= acc_d;
            bias_q   <= bias_d;
            tdata_q  <= tdata_d;
            tag_q    <= tag_d;
            first_q  <= first_d;
        end
    end

    assign bus.data_addr   = k_q;
    assign bus.weight_addr = waddr_q;
    assign bus.bias_addr   = neuron_q;
    assign bus.temp_addr   = neuron_q;
    assign bus.temp_wren   = (state_q == StWrite);
    assign bus.temp_data   = (state_q == StWrite) ? res : tdata_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.ready       = (state_q == StDone);
endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench for fc_layer_engine: two instances (MEM_LAT 1 and 3) with registered memory
// models, a write/ready monitor, and hand-computed expected results.
module tb_fc_layer_engine;
    localparam int unsigned NIn  = 4;
    localparam int unsigned NOut = 3;
    localparam int unsigned DW   = 16;
    localparam int unsigned FB   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_r = 1'b0;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    fc_layer_engine_if #(.N_IN(NIn), .N_OUT(NOut), .DATA_W(DW)) fc_if1 ();
    fc_layer_engine_if #(.N_IN(NIn), .N_OUT(NOut), .DATA_W(DW)) fc_if3 ();

    fc_layer_engine #(.N_IN(NIn), .N_OUT(NOut), .DATA_W(DW), .FRAC_BITS(FB), .MEM_LAT(1)) u_dut1 (
        .Clk(clk), .Reset(rst), .bus(fc_if1)
    );
    fc_layer_engine #(.N_IN(NIn), .N_OUT(NOut), .DATA_W(DW), .FRAC_BITS(FB), .MEM_LAT(3)) u_dut3 (
        .Clk(clk), .Reset(rst), .bus(fc_if3)
    );

    logic signed [DW-1:0] data_mem [NIn];
    logic signed [DW-1:0] weight_mem [NIn*NOut];
    logic signed [DW-1:0] bias_mem [NOut];
    logic signed [DW-1:0] d1, w1, b1;
    logic signed [DW-1:0] d3 [3];
    logic signed [DW-1:0] w3 [3];
    logic signed [DW-1:0] b3 [3];

    always @(posedge clk) begin
        d1 <= data_mem[fc_if1.data_addr];
        w1 <= weight_mem[fc_if1.weight_addr];
        b1 <= bias_mem[fc_if1.bias_addr];
        d3[0] <= data_mem[fc_if3.data_addr];
        w3[0] <= weight_mem[fc_if3.weight_addr];
        b3[0] <= bias_mem[fc_if3.bias_addr];
        for (int i = 1; i < 3; i++) begin
            d3[i] <= d3[i-1];
            w3[i] <= w3[i-1];
            b3[i] <= b3[i-1];
        end
    end

    assign fc_if1.curdata   = d1;
    assign fc_if1.curweight = w1;
    assign fc_if1.curbias   = b1;
    assign fc_if1.start     = start_r & ~sel;
    assign fc_if3.curdata   = d3[2];
    assign fc_if3.curweight = w3[2];
    assign fc_if3.curbias   = b3[2];
    assign fc_if3.start     = start_r & sel;

    logic                 m_wren, m_ready, m_busy;
    logic [1:0]           m_addr;
    logic signed [DW-1:0] m_data;
    assign m_wren  = sel ? fc_if3.temp_wren : fc_if1.temp_wren;
    assign m_ready = sel ? fc_if3.ready     : fc_if1.ready;
    assign m_busy  = sel ? fc_if3.busy      : fc_if1.busy;
    assign m_addr  = sel ? fc_if3.temp_addr : fc_if1.temp_addr;
    assign m_data  = sel ? fc_if3.temp_data : fc_if1.temp_data;

    int cyc = 0;
    int e0 = 0;
    int wa[$], wd[$], wc[$], rc[$];
    int busy_nr = 0;
    int idle_nr = 0;
    int n_checks = 0;
    int n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_wren) begin
            wa.push_back(int'(m_addr));
            wd.push_back(int'(m_data));
            wc.push_back(cyc - e0);
        end
        if (m_ready) rc.push_back(cyc - e0);
        if (m_busy && !m_ready) busy_nr++;
        if (!m_busy && rc.size() == 1) idle_nr++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input int d, input int w, input int b);
        for (int i = 0; i < NIn; i++) data_mem[i] = DW'(d);
        for (int i = 0; i < NIn * NOut; i++) weight_mem[i] = DW'(w);
        for (int i = 0; i < NOut; i++) bias_mem[i] = DW'(b);
    endtask

    task automatic clear_mon();
        wa.delete(); wd.delete(); wc.delete(); rc.delete();
        busy_nr = 0;
        idle_nr = 0;
    endtask

    task automatic launch();
        clear_mon();
        start_r = 1'b1;
        e0 = cyc;
        @(negedge clk);
        start_r = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int n);
        int t = 0;
        while (rc.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (rc.size() < n) check_eq({tag, "_ready_timeout"}, rc.size(), n);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input int v0, input int v1, input int v2,
                                input int per);
        int exp_v[3];
        exp_v = '{v0, v1, v2};
        check_eq({tag, "_nwr"}, wa.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < wa.size()) begin
                check_eq($sformatf("%s_addr%0d", tag, i), wa[i], i);
                check_eq($sformatf("%s_data%0d", tag, i), wd[i], exp_v[i]);
                check_eq($sformatf("%s_cyc%0d", tag, i), wc[i], per * (i + 1));
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_data_addr"}, int'(fc_if1.data_addr), 0);
        check_eq({tag, "_weight_addr"}, int'(fc_if1.weight_addr), 0);
        check_eq({tag, "_bias_addr"}, int'(fc_if1.bias_addr), 0);
        check_eq({tag, "_temp_addr"}, int'(fc_if1.temp_addr), 0);
        check_eq({tag, "_temp_data"}, int'(fc_if1.temp_data), 0);
        check_eq({tag, "_temp_wren"}, int'(fc_if1.temp_wren), 0);
        check_eq({tag, "_busy"}, int'(fc_if1.busy), 0);
        check_eq({tag, "_ready"}, int'(fc_if1.ready), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int neg_exp, neg_sat, row1;
`ifdef FC_RELU_EN
        neg_exp = 0;
        neg_sat = 0;
        row1    = 0;
`else
        neg_exp = -1024;
        neg_sat = -32768;
        row1    = -65;
`endif
        fill(256, 128, 256);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset_busy3", int'(fc_if3.busy), 0);

        // 4 * (1.0 * 0.5) + 1.0 = 3.0
        launch();
        wait_ready("basic", 1);
        check_writes("basic", 768, 768, 768, 6);
        if (rc.size() > 0) check_eq("basic_ready_cyc", rc[0], 19);
        check_eq("basic_nready", rc.size(), 1);
        check_eq("basic_busy_cycles", busy_nr, 18);

        fill(256, -256, 0);
        launch();
        wait_ready("signed", 1);
        check_writes("signed", neg_exp, neg_exp, neg_exp, 6);

        fill(32767, 32767, 32767);
        launch();
        wait_ready("sat_hi", 1);
        check_writes("sat_hi", 32767, 32767, 32767, 6);

        fill(32767, -32768, 0);
        launch();
        wait_ready("sat_lo", 1);
        check_writes("sat_lo", neg_sat, neg_sat, neg_sat, 6);

        // MEM_LAT=3: data {1, 2, -1, 129/256}, row weights {1.0, -0.5, 0.25}, bias = row*256
        data_mem[0] = 16'sd256;
        data_mem[1] = 16'sd512;
        data_mem[2] = -16'sd256;
        data_mem[3] = 16'sd129;
        for (int i = 0; i < NIn; i++) begin
            weight_mem[i]         = 16'sd256;
            weight_mem[NIn + i]   = -16'sd128;
            weight_mem[2*NIn + i] = 16'sd64;
        end
        for (int i = 0; i < NOut; i++) bias_mem[i] = DW'(i * 256);
        sel = 1'b1;
        launch();
        wait_ready("lat3", 1);
        check_writes("lat3", 641, row1, 672, 8);
        if (rc.size() > 0) check_eq("lat3_ready_cyc", rc[0], 25);
        sel = 1'b0;

        // Extra start during neuron 1, then reset before its write
        fill(256, 128, 256);
        launch();
        repeat (6) @(negedge clk);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midrst");
        repeat (20) @(negedge clk);
        check_eq("midrst_nwr", wa.size(), 1);
        if (wa.size() > 0) check_eq("midrst_addr0", wa[0], 0);
        check_eq("midrst_nready", rc.size(), 0);
        launch();
        wait_ready("restart", 1);
        check_writes("restart", 768, 768, 768, 6);

        // start held high: two passes with one IDLE cycle between them
        clear_mon();
        start_r = 1'b1;
        e0 = cyc;
        for (int t = 0; t < 300 && rc.size() < 2; t++) @(negedge clk);
        start_r = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("b2b_nready", rc.size(), 2);
        check_eq("b2b_nwr", wa.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < wa.size()) begin
                check_eq($sformatf("b2b_addr%0d", i), wa[i], i % 3);
                check_eq($sformatf("b2b_data%0d", i), wd[i], 768);
                check_eq($sformatf("b2b_cyc%0d", i), wc[i], 6 * (i % 3 + 1) + 20 * (i / 3));
            end
        end
        if (rc.size() > 1) begin
            check_eq("b2b_ready0", rc[0], 19);
            check_eq("b2b_ready1", rc[1], 39);
        end
        check_eq("b2b_idle_gap", idle_nr, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fc_layer_engine.md
# fc_layer_engine

Parametrised fully-connected layer engine for the number-recognition datapath. It computes `N_OUT` neurons, each a fixed-point dot product of an `N_IN`-element input vector with one weight row, plus a per-neuron bias. Results are saturated to the data width and written to the temp RAM. The weight, data and bias memories are synchronous with a configurable read latency, and the engine issues one address per cycle to keep a pipelined multiply-accumulate busy.

## Interface
Parameters:
- `N_IN`, 48: input vector length (≥1).
- `N_OUT`, 10: neuron count (≥1).
- `DATA_W`, 32: signed width of data, weight, bias and result.
- `FRAC_BITS`, 16: fractional bits of the fixed-point format.
- `MEM_LAT`, 1: read latency of the data, weight and bias memories, in cycles (1..3).
- Derived widths (localparams):
  - `DAW = max(1, clog2(N_IN))`
  - `WAW = max(1, clog2(N_IN*N_OUT))`
  - `OAW = max(1, clog2(N_OUT))`
  - `ACC_W = 2*DATA_W + clog2(N_IN) + 1`

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  clock.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a layer pass; sampled only in IDLE.
- `curdata`  in  DATA_W  signed data word, valid `MEM_LAT` cycles after `data_addr`.
- `curweight`  in  DATA_W  signed weight word, same latency as `curdata`.
- `curbias`  in  DATA_W  signed bias word, same latency as `curdata`.
- `data_addr`  out  DAW  input vector index.
- `weight_addr`  out  WAW  weight index; row-major, equal to `neuron*N_IN + k`.
- `bias_addr`  out  OAW  equal to the current neuron index.
- `temp_addr`  out  OAW  result write address.
- `temp_data`  out  DATA_W  result write data.
- `temp_wren`  out  1  result write strobe.
- `busy`  out  1  high in every state except IDLE.
- `ready`  out  1  one-cycle pulse at end of pass.

## Operation
States are IDLE, ISSUE, DRAIN, WRITE and DONE.
- **IDLE:**
  - If `start` is high: go to ISSUE, with neuron=0, k=0 and accumulator=0.
- **ISSUE:** lasts N_IN cycles.
  - Drive `data_addr=k`, `weight_addr=neuron*N_IN+k`, `bias_addr=neuron`.
  - Increment k each cycle.
  - After k=N_IN-1: go to DRAIN.
- **DRAIN:** lasts MEM_LAT cycles.
  - No new addresses are issued.
  - Address outputs hold their last values.
- **Accumulate:** a valid-tag shift register of depth `MEM_LAT` follows each issued address.
  - When a tagged sample returns: `acc += sext((curdata*curweight) >>> FRAC_BITS)`.
  - The product is full 2*DATA_W signed; the shift is arithmetic (floor).
- **Bias capture:** `curbias` is captured on the first returning sample of each neuron. `bias_addr` is stable from the first ISSUE cycle, so this sample is valid.
- **WRITE:** lasts 1 cycle.
  - `temp_wren=1`, `temp_addr=neuron`, `temp_data=sat(f(acc + sext(bias)))`.
  - `f` is the ReLU when it is compiled in, otherwise identity.
  - `sat` clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Clear acc.
  - If neuron==N_OUT-1: go to DONE. Otherwise increment neuron, set k=0 and go to ISSUE.
- **DONE:** lasts 1 cycle.
  - `ready=1`, neuron=0.
  - Go to IDLE.
- `start` in any non-IDLE state is ignored and is not queued.
- `temp_data` holds its last written value outside WRITE.

## Timing
- **Reset:** any cycle with `Reset` high forces IDLE at the next edge and clears the accumulator, counters and tag pipeline. Reset values of all outputs:
  - `data_addr`, `weight_addr`, `bias_addr`, `temp_addr`, `temp_data` = 0.
  - `temp_wren`, `busy`, `ready` = 0.
- **Reset mid-pass:** the partial neuron is discarded and no write occurs. The next `start` restarts at neuron 0.
- **Per-neuron cycles:** N_IN + MEM_LAT + 1.
- **Pass latency:** `start` is sampled at edge E0. The WRITE for neuron n occupies cycle E0 + (n+1)(N_IN+MEM_LAT+1). `ready` is high during cycle E0 + N_OUT(N_IN+MEM_LAT+1) + 1. `busy` rises in the cycle after E0 and falls with the return to IDLE.
- **Back-to-back passes:** the earliest next `start` is sampled in the IDLE cycle following DONE.
- **Writes:** exactly N_OUT `temp_wren` pulses per pass, with addresses ascending 0..N_OUT-1.

## Configuration
- `FC_RELU_EN` defined: negative pre-saturation sums are written as 0. Saturation applies only to the upper bound.
- `FC_RELU_EN` undefined: signed results are written, saturated at both bounds. This is the output-layer mode.

## Test plan
Common setup: N_IN=4, N_OUT=3, DATA_W=16, FRAC_BITS=8, MEM_LAT=1, without `FC_RELU_EN` unless noted.
- **Basic dot product:**
  - Stimulus: all data=256 (1.0), weights=128 (0.5), bias=256.
  - Required: 3 writes of 768 at addresses 0, 1, 2; `ready` at E0+19; `busy` high for 18 cycles.
- **Signed sum and ReLU:**
  - Stimulus: weights=-256, data=256, bias=0.
  - Required: without `FC_RELU_EN`, writes -1024; with it, writes 0.
- **Saturation:**
  - Stimulus: data=weights=32767, bias=32767.
  - Required: writes 32767.
  - Stimulus: weights=-32768, data=32767.
  - Required: without `FC_RELU_EN`, writes -32768.
- **Read latency:**
  - Stimulus: MEM_LAT=3 model, a distinct weight per row, and bias=row index × 256.
  - Required: correct per-row results; `ready` at E0 + 3·8 + 1 = E0+25.
- **Reset mid-pass and start while busy:**
  - Stimulus: pulse `start` during ISSUE of neuron 1. Then assert `Reset` during neuron 1.
  - Required: the extra `start` has no effect; after `Reset`, all outputs are 0 and no write to address 1 occurs.
  - Stimulus: a new `start` after reset.
  - Required: 3 writes from address 0.
- **Back-to-back passes:**
  - Stimulus: `start` held high continuously.
  - Required: consecutive passes separated by exactly one IDLE cycle; identical results each pass.
